// File: rtl/cpu_run_controller.sv
// CPU reset/run sequencer: PLL-lock gated reset hold, debounced reset button, clock-gate enable.
// Define STEP_MODE_EN to add the single-step clock-gating feature.
module cpu_run_controller #(
  parameter int DEBOUNCE_CYCLES   = 65536,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter int CNT_W             = 17
) (
  input  logic       clkout,
  input  logic       ext_reset,
  input  logic       pll_lock,
  input  logic       btn_reset_n,
  input  logic       btn_step_n,
  input  logic       step_mode,
  output logic       cpu_reset,
  output logic       cpu_clk_en,
  output logic [2:0] state_o,
  output logic [7:0] reset_count
);

  localparam logic [2:0] S_POR      = 3'd0;
  localparam logic [2:0] S_HOLD     = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DEBOUNCE = 3'd3;
  localparam logic [2:0] S_WAIT_REL = 3'd4;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             lock_p0, lock_s;
  logic             btn_p0, btn_s;
  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             count_inc;
  logic             reset_nx, clk_en_nx;
  logic             step_fire;

  // Input synchronisers; the button idles released so a reset never looks like a press
  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      lock_p0 <= 1'b0;
      lock_s  <= 1'b0;
      btn_p0  <= 1'b1;
      btn_s   <= 1'b1;
    end else begin
      lock_p0 <= pll_lock;
      lock_s  <= lock_p0;
      btn_p0  <= btn_reset_n;
      btn_s   <= btn_p0;
    end
  end

`ifdef STEP_MODE_EN
  logic             step_p0, step_s;
  logic             mode_p0, mode_s;
  logic             step_armed;
  logic [CNT_W-1:0] step_cnt;

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      step_p0 <= 1'b1;
      step_s  <= 1'b1;
      mode_p0 <= 1'b0;
      mode_s  <= 1'b0;
    end else begin
      step_p0 <= btn_step_n;
      step_s  <= step_p0;
      mode_p0 <= step_mode;
      mode_s  <= mode_p0;
    end
  end

  assign step_fire = (state == S_RUN) && !step_s && step_armed && (step_cnt == DEB_LAST);

  // One pulse per press; re-armed only by a release seen while running
  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      step_cnt   <= '0;
      step_armed <= 1'b1;
    end else if (state != S_RUN) begin
      step_cnt   <= '0;
    end else if (step_s) begin
      step_cnt   <= '0;
      step_armed <= 1'b1;
    end else if (step_armed) begin
      if (step_cnt == DEB_LAST) begin
        step_cnt   <= '0;
        step_armed <= 1'b0;
      end else begin
        step_cnt   <= step_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_step;
  assign unused_step = btn_step_n ^ step_mode;
  assign step_fire   = 1'b0;
`endif

  // State and shared counter register
  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      state <= S_POR;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state; losing lock outranks every button event
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    count_inc = 1'b0;
    if (state != S_POR && !lock_s) begin
      state_nx = S_POR;
      cnt_nx   = '0;
    end else begin
      case (state)
        S_POR: begin
          if (lock_s) begin
            state_nx = S_HOLD;
            cnt_nx   = '0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx   = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!btn_s) begin
            state_nx = S_DEBOUNCE;
            cnt_nx   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (btn_s) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end else if (cnt == DEB_LAST) begin
            state_nx  = S_WAIT_REL;
            cnt_nx    = '0;
            count_inc = 1'b1;
          end else begin
            cnt_nx    = cnt + 1'b1;
          end
        end
        S_WAIT_REL: begin
          if (btn_s) begin
            state_nx = S_HOLD;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = S_POR;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so the registered copies line up with state
  always_comb begin
    reset_nx  = 1'b1;
    clk_en_nx = 1'b0;
    case (state_nx)
      S_HOLD, S_WAIT_REL: clk_en_nx = 1'b1;
      S_DEBOUNCE: begin
        reset_nx  = 1'b0;
        clk_en_nx = 1'b1;
      end
      S_RUN: begin
        reset_nx  = 1'b0;
`ifdef STEP_MODE_EN
        clk_en_nx = !mode_s || step_fire;
`else
        clk_en_nx = 1'b1;
`endif
      end
      default: begin
        reset_nx  = 1'b1;
        clk_en_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      cpu_reset   <= 1'b1;
      cpu_clk_en  <= 1'b0;
      reset_count <= '0;
    end else begin
      cpu_reset  <= reset_nx;
      cpu_clk_en <= clk_en_nx;
      if (count_inc && reset_count != 8'hFF)
        reset_count <= reset_count + 8'd1;
    end
  end

  assign state_o = state;

endmodule
